bram_responder: RTL and testbench

- Responder (memory) end of the 32-bit BRAM port driven by the CPU memory controller.
- Word-addressed synchronous RAM with byte-lane write enables, read-first semantics and configurable read latency (1..3 cycles).
- Out-of-range detection.
- Secondary preload port (valid/ready) for loading a program image while the CPU port is idle.
- Used in simulation and as the synthesizable stand-in for the BRAM generator.

---
 rtl/bram_responder.sv | 98 +++++++++
 tb/tb_bram_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_responder.sv
// rtl/bram_responder.sv - word-addressed BRAM responder with lane writes, read pipeline and preload port
module bram_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        err_oob,
  input  logic        err_clr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
      $error("bram_responder: READ_LATENCY must be 1..3");
    end
  endgenerate

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] ld_idx;
  logic                  oob;
  logic                  ld_oob;
  logic                  rd_acc;
  logic                  cpu_wr;
  logic                  ld_fire;
  logic                  run_q;
  logic [31:0]           pd [READ_LATENCY];
  logic [READ_LATENCY-1:0] pv;

  assign idx     = addr[ADDR_WIDTH-1:0];
  assign ld_idx  = ld_addr[ADDR_WIDTH-1:0];
  assign oob     = |addr[31:ADDR_WIDTH];
  assign ld_oob  = |ld_addr[31:ADDR_WIDTH];
  // Nothing is accepted while reset is asserted, so writes in the reset cycle are dropped.
  assign rd_acc  = rstn & en;
  assign cpu_wr  = rd_acc & (|we) & ~oob;
  // The CPU port always wins; the preloader only gets idle cycles after reset has released.
  assign ld_ready = run_q & rstn & ~en;
  assign ld_fire  = ld_valid & ld_ready;

  assign dout       = pd[READ_LATENCY-1];
  assign dout_valid = pv[READ_LATENCY-1];

  // Remembers that reset has been released, gating the preload handshake.
  always_ff @(posedge clk) begin
    run_q <= rstn;
  end

  // RAM array: per-lane CPU writes or full-word preload writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (cpu_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= din[8*i +: 8];
      end
    end else if (ld_fire && !ld_oob) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // Read pipeline: stage 0 samples the pre-write word, later stages shift only on valid so dout holds.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pv <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pd[k] <= '0;
    end else begin
      pv[0] <= en;
      if (en) pd[0] <= oob ? 32'h0000_0000 : mem[idx];
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) pd[k] <= pd[k-1];
      end
    end
  end

  // Sticky out-of-range flag; a new error takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_oob <= 1'b0;
    end else if ((rd_acc && oob) || (ld_fire && ld_oob)) begin
      err_oob <= 1'b1;
    end else if (err_clr) begin
      err_oob <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_responder.sv
// tb/tb_bram_responder.sv - directed self-checking bench for bram_responder at latencies 1, 2 and 3
module tb_bram_responder;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] din;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        err_clr;

  logic [31:0] dout1, dout2, dout3;
  logic        dv1, dv2, dv3;
  logic        rdy1, rdy2, rdy3;
  logic        err1, err2, err3;

  int n_vec;
  int n_err;

  bram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(1)) u1 (
    .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout1), .dout_valid(dv1), .ld_valid(ld_valid), .ld_ready(rdy1),
    .ld_addr(ld_addr), .ld_data(ld_data), .err_oob(err1), .err_clr(err_clr));

  bram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2)) u2 (
    .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout2), .dout_valid(dv2), .ld_valid(ld_valid), .ld_ready(rdy2),
    .ld_addr(ld_addr), .ld_data(ld_data), .err_oob(err2), .err_clr(err_clr));

  bram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(3)) u3 (
    .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .din(din),
    .dout(dout3), .dout_valid(dv3), .ld_valid(ld_valid), .ld_ready(rdy3),
    .ld_addr(ld_addr), .ld_data(ld_data), .err_oob(err3), .err_clr(err_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0; en = 1'b0; we = 4'h0; addr = '0; din = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; err_clr = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_dout1", dout1, 32'h0);
    chk("rst_dv1", dv1, 1'b0);
    chk("rst_dout3", dout3, 32'h0);
    chk("rst_err1", err1, 1'b0);
    chk("rst_ldrdy1", rdy1, 1'b0);
    rstn = 1'b1;
    #1 chk("rel_ldrdy_before_edge", rdy1, 1'b0);
    tick();
    chk("rel_ldrdy_after_edge", rdy1, 1'b1);

    // Program image via the preload port
    preload(32'd0, 32'h10);
    chk("preload_no_dv", dv1, 1'b0);
    preload(32'd1, 32'h11);
    preload(32'd2, 32'h12);
    preload(32'd7, 32'hAAAA_BBBB);

    // Full-word write then read
    en = 1'b1; we = 4'hF; addr = 32'd5; din = 32'h1234_5678;
    #1 chk("ldrdy_low_on_en", rdy1, 1'b0);
    tick();
    we = 4'h0;
    tick();
    chk("wr_rd_dout1", dout1, 32'h1234_5678);
    chk("wr_rd_dv1", dv1, 1'b1);
    en = 1'b0;
    tick();
    chk("hold_dv1", dv1, 1'b0);
    chk("hold_dout1", dout1, 32'h1234_5678);
    chk("wr_rd_dout2", dout2, 32'h1234_5678);
    chk("wr_rd_dv2", dv2, 1'b1);
    tick();
    chk("wr_rd_dout3", dout3, 32'h1234_5678);
    chk("wr_rd_dv3", dv3, 1'b1);
    chk("l2_dv_done", dv2, 1'b0);
    tick(); tick();

    // Upper-half lane write, read-first
    en = 1'b1; we = 4'b1100; addr = 32'd7; din = 32'h1111_2222;
    tick();
    chk("lane_readfirst", dout1, 32'hAAAA_BBBB);
    we = 4'h0;
    tick();
    chk("lane_result", dout1, 32'h1111_BBBB);
    en = 1'b0;
    tick(); tick(); tick();

    // Streaming reads, latency 1 and 3
    en = 1'b1; addr = 32'd0;
    tick();
    chk("strm_l1_0", dout1, 32'h10);
    addr = 32'd1;
    tick();
    chk("strm_l1_1", dout1, 32'h11);
    chk("strm_l3_dv_early", dv3, 1'b0);
    addr = 32'd2;
    tick();
    chk("strm_l1_2", dout1, 32'h12);
    chk("strm_l3_0", dout3, 32'h10);
    chk("strm_l3_dv0", dv3, 1'b1);
    en = 1'b0;
    tick();
    chk("strm_l3_1", dout3, 32'h11);
    chk("strm_l3_dv1", dv3, 1'b1);
    chk("strm_l1_idle", dv1, 1'b0);
    tick();
    chk("strm_l3_2", dout3, 32'h12);
    chk("strm_l3_dv2", dv3, 1'b1);
    tick();
    chk("strm_l3_dv_end", dv3, 1'b0);
    chk("strm_l3_hold", dout3, 32'h12);

    // Out-of-range write and read
    en = 1'b1; we = 4'hF; addr = 32'h400; din = 32'hFFFF_FFFF;
    tick();
    chk("oob_wr_dout", dout1, 32'h0);
    chk("oob_wr_dv", dv1, 1'b1);
    chk("oob_err_set", err1, 1'b1);
    we = 4'h0;
    tick();
    chk("oob_rd_dout", dout1, 32'h0);
    chk("oob_rd_dv", dv1, 1'b1);
    addr = 32'd0;
    tick();
    chk("oob_alias_intact", dout1, 32'h10);
    chk("oob_err_sticky", err1, 1'b1);
    en = 1'b0; err_clr = 1'b1;
    #1 chk("oob_err_before_clr", err1, 1'b1);
    tick();
    chk("oob_err_cleared", err1, 1'b0);

    // Set wins over clear
    en = 1'b1; addr = 32'h8000_0000;
    tick();
    chk("oob_set_wins", err1, 1'b1);
    en = 1'b0;
    tick();
    chk("oob_clr_again", err1, 1'b0);
    err_clr = 1'b0;

    // Out-of-range preload
    preload(32'h401, 32'h0);
    chk("ld_oob_err", err1, 1'b1);
    en = 1'b1; addr = 32'd1;
    tick();
    chk("ld_oob_intact", dout1, 32'h11);
    en = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick(); tick();

    // Preload arbitration against CPU traffic
    ld_valid = 1'b1; ld_addr = 32'd3; ld_data = 32'hCAFE_F00D;
    en = 1'b1; we = 4'h0; addr = 32'd0;
    #1 chk("arb_rdy_c0", rdy1, 1'b0);
    tick();
    chk("arb_rdy_c1", rdy1, 1'b0);
    tick();
    en = 1'b0;
    #1 chk("arb_rdy_free", rdy1, 1'b1);
    tick();
    ld_valid = 1'b0;
    chk("arb_no_dv", dv1, 1'b0);
    en = 1'b1; addr = 32'd3;
    tick();
    chk("arb_readback", dout1, 32'hCAFE_F00D);
    en = 1'b0;
    tick(); tick(); tick();

    // Reset mid-read; the write during the reset cycle must be dropped
    en = 1'b1; we = 4'h0; addr = 32'd5;
    tick();
    rstn = 1'b0; we = 4'hF; din = 32'hDEAD_BEEF;
    #1 chk("midrst_ldrdy", rdy2, 1'b0);
    tick();
    rstn = 1'b1; en = 1'b0; we = 4'h0;
    chk("midrst_dv2", dv2, 1'b0);
    chk("midrst_dout2", dout2, 32'h0);
    tick();
    chk("midrst_dv2_after", dv2, 1'b0);
    chk("midrst_dv3_after", dv3, 1'b0);
    tick();
    chk("midrst_dv3_late", dv3, 1'b0);
    chk("midrst_dout3", dout3, 32'h0);
    en = 1'b1; addr = 32'd5;
    tick();
    en = 1'b0;
    chk("midrst_word5_l1", dout1, 32'h1234_5678);
    tick();
    chk("midrst_word5_l2", dout2, 32'h1234_5678);
    chk("midrst_word5_dv2", dv2, 1'b1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
